// File: rtl/irq_ctrl_if.sv
// CPU-side register bus of the interrupt controller: chip select, write
// strobe, register select, write data and registered read data.
interface irq_ctrl_if;
  logic       cs;
  logic       we;
  logic [2:0] rs;
  logic [7:0] din;
  logic [7:0] dout;

  // CPU / SoC side drives the access and receives read data.
  modport master (
    output cs,
    output we,
    output rs,
    output din,
    input  dout
  );

  // Controller side decodes the access and returns read data.
  modport slave (
    input  cs,
    input  we,
    input  rs,
    input  din,
    output dout
  );
endinterface

// File: rtl/irq_ctrl.sv
// Eight-source interrupt controller for the 6502 SoC.
// Each source is synchronised, optionally edge-latched, masked by a
// per-source enable and OR-reduced into a registered level IRQ. A vector
// register returns the index of the highest-priority (lowest-numbered)
// active source so the ISR can dispatch with a single read.
module irq_ctrl #(
  parameter int unsigned SYNC_STAGES = 2  // 2..3
) (
  input  logic         clk,
  input  logic         reset,
  irq_ctrl_if.slave    bus,
  input  logic [7:0]   src,
  output logic         irq
);

  localparam logic [2:0] RS_STATUS = 3'd0;
  localparam logic [2:0] RS_ENABLE = 3'd1;
  localparam logic [2:0] RS_MODE   = 3'd2;
  localparam logic [2:0] RS_ACTIVE = 3'd3;
  localparam logic [2:0] RS_VECTOR = 3'd4;
  localparam logic [2:0] RS_SET    = 3'd5;

  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] s;
  logic [7:0] prev;
  logic [7:0] rise;
  logic [7:0] en;
  logic [7:0] mode;
  logic [7:0] elat;
  logic [7:0] pend;
  logic [7:0] act;
  logic [7:0] vec;
  logic [7:0] rdata;
  logic [7:0] elat_set;
  logic [7:0] elat_clr;
  logic       wr;
  logic       rd;
  logic       wr_status;
  logic       wr_enable;
  logic       wr_mode;
  logic       wr_set;

  // Synchroniser chain on every source bit; the last stage is the sampled source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= src;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev;

  // Previous synchronised value, for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
    end else begin
      prev <= s;
    end
  end

  // Register access decode.
  always_comb begin
    wr        = bus.cs & bus.we;
    rd        = bus.cs & ~bus.we;
    wr_status = wr && (bus.rs == RS_STATUS);
    wr_enable = wr && (bus.rs == RS_ENABLE);
    wr_mode   = wr && (bus.rs == RS_MODE);
    wr_set    = wr && (bus.rs == RS_SET);
  end

  // Edge-latch set/clear terms; set uses the mode in force before this write.
  always_comb begin
    elat_set = mode & (rise | (wr_set ? bus.din : '0));
    elat_clr = (wr_status ? bus.din : '0) | (wr_mode ? (bus.din & ~mode) : '0);
  end

  // Edge latches: set has priority over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elat <= '0;
    end else begin
      elat <= elat_set | (elat & ~elat_clr);
    end
  end

  // Enable and mode registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en   <= '0;
      mode <= '0;
    end else begin
      if (wr_enable) en   <= bus.din;
      if (wr_mode)   mode <= bus.din;
    end
  end

  // Pending and active source vectors.
  always_comb begin
    pend = (mode & elat) | (~mode & s);
    act  = pend & en;
  end

  // Priority encoder: lowest set bit of act wins; 8'h80 when nothing active.
  always_comb begin
    vec = 8'h80;
    for (int unsigned i = 8; i > 0; i--) begin
      if (act[i-1]) vec = {5'b0, 3'(i - 1)};
    end
  end

  // Read data selection.
  always_comb begin
    rdata = '0;
    case (bus.rs)
      RS_STATUS: rdata = pend;
      RS_ENABLE: rdata = en;
      RS_MODE:   rdata = mode;
      RS_ACTIVE: rdata = act;
      RS_VECTOR: rdata = vec;
      default:   rdata = '0;
    endcase
  end

  // Registered read data; holds its value when no read is in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.dout <= '0;
    end else if (rd) begin
      bus.dout <= rdata;
    end
  end

  // Registered interrupt request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |act;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register reads go through a scoreboard
// queue (expected value pushed when the read is issued, popped when dout is
// valid one edge later); irq and latency checks compare against constants.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src;
  logic       irq;
  int         checks = 0;
  int         errors = 0;
  string      sb_tag[$];
  logic [7:0] sb_exp[$];

  irq_ctrl_if bus();

  irq_ctrl #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .src   (src),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reg_write(input logic [2:0] r, input logic [7:0] d);
    bus.cs  = 1'b1;
    bus.we  = 1'b1;
    bus.rs  = r;
    bus.din = d;
    tick();
    bus.cs  = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic reg_read(input string tag, input logic [2:0] r, input logic [7:0] exp);
    bus.cs = 1'b1;
    bus.we = 1'b0;
    bus.rs = r;
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
    tick();
    bus.cs = 1'b0;
    check(sb_tag.pop_front(), bus.dout, sb_exp.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    src     = '0;
    bus.cs  = 1'b0;
    bus.we  = 1'b0;
    bus.rs  = '0;
    bus.din = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("por_irq", {7'b0, irq}, 8'h00);
    check("por_dout", bus.dout, 8'h00);

    // Asynchronous reset mid-run with irq high and dout non-zero
    reg_write(3'd1, 8'h01);
    src = 8'h01;
    repeat (4) tick();
    reg_read("pre_rst_enable", 3'd1, 8'h01);
    check("pre_rst_irq", {7'b0, irq}, 8'h01);
    #2 reset = 1'b1;
    src = '0;
    #1;
    check("async_rst_irq", {7'b0, irq}, 8'h00);
    check("async_rst_dout", bus.dout, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    reg_read("rst_enable", 3'd1, 8'h00);
    reg_read("rst_mode", 3'd2, 8'h00);
    reg_read("rst_status", 3'd0, 8'h00);
    reg_read("rst_vector", 3'd4, 8'h80);

    // Level source
    reg_write(3'd1, 8'h01);
    src = 8'h01;
    tick();
    check("lvl_rise_e1", {7'b0, irq}, 8'h00);
    tick();
    check("lvl_rise_e2", {7'b0, irq}, 8'h00);
    tick();
    check("lvl_rise_e3", {7'b0, irq}, 8'h01);
    src = 8'h00;
    tick();
    tick();
    check("lvl_fall_e2", {7'b0, irq}, 8'h01);
    tick();
    check("lvl_fall_e3", {7'b0, irq}, 8'h00);
    src = 8'h01;
    repeat (3) tick();
    reg_write(3'd0, 8'hFF);
    tick();
    check("lvl_status_wr_irq", {7'b0, irq}, 8'h01);
    reg_read("lvl_status", 3'd0, 8'h01);
    src = 8'h00;
    repeat (3) tick();
    check("lvl_off_irq", {7'b0, irq}, 8'h00);

    // Edge source and clear
    reg_write(3'd2, 8'h04);
    reg_write(3'd1, 8'h04);
    src = 8'h04;
    tick();
    src = 8'h00;
    check("edge_e1", {7'b0, irq}, 8'h00);
    tick();
    check("edge_e2", {7'b0, irq}, 8'h00);
    tick();
    check("edge_e3", {7'b0, irq}, 8'h00);
    tick();
    check("edge_e4", {7'b0, irq}, 8'h01);
    repeat (4) tick();
    check("edge_hold", {7'b0, irq}, 8'h01);
    reg_read("edge_status", 3'd0, 8'h04);
    reg_read("edge_vector", 3'd4, 8'h02);
    reg_read("edge_active", 3'd3, 8'h04);
    reg_write(3'd0, 8'h04);
    check("edge_clr_same", {7'b0, irq}, 8'h01);
    tick();
    check("edge_clr_next", {7'b0, irq}, 8'h00);

    // Priority
    reg_write(3'd1, 8'hFF);
    reg_write(3'd2, 8'hFF);
    reg_write(3'd5, 8'hA0);
    reg_read("prio_vec_a0", 3'd4, 8'h05);
    check("prio_irq", {7'b0, irq}, 8'h01);
    reg_write(3'd0, 8'h20);
    reg_read("prio_vec_80", 3'd4, 8'h07);
    reg_write(3'd0, 8'h80);
    reg_read("prio_vec_none", 3'd4, 8'h80);
    check("prio_irq_off", {7'b0, irq}, 8'h00);
    reg_read("set_reads_zero", 3'd5, 8'h00);

    // Simultaneous set (rise[3]) and STATUS clear of bit 3
    src = 8'h08;
    tick();
    tick();
    reg_write(3'd0, 8'h08);
    reg_read("setclr_status", 3'd0, 8'h08);
    src = 8'h00;
    repeat (3) tick();
    reg_write(3'd0, 8'h08);
    reg_read("setclr_cleared", 3'd0, 8'h00);

    // Mode switch: re-entering edge mode clears the stale latch
    reg_write(3'd5, 8'h02);
    reg_read("ms_status_set", 3'd0, 8'h02);
    reg_write(3'd2, 8'h00);
    reg_write(3'd2, 8'h02);
    reg_read("ms_mode", 3'd2, 8'h02);

    // Read latency: exactly one edge, then dout holds
    bus.cs = 1'b1;
    bus.we = 1'b0;
    bus.rs = 3'd0;
    #1;
    check("lat_before_edge", bus.dout, 8'h02);
    @(negedge clk);
    bus.cs = 1'b0;
    check("ms_status_bit1", bus.dout, 8'h00);
    tick();
    tick();
    check("lat_hold", bus.dout, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
